// File: rtl/xreg_seq.sv
// Sequencer for the X register bit-slice array: one command at a time, emitting
// registered one-hot next-value selects, the wrx write clock and the rdx read enable.
module xreg_seq #(
   parameter int unsigned CNT_W     = 4,
   parameter int unsigned RD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             xiz,
   output logic             xip,
   output logic             xis,
   output logic             xid,
   output logic             wrx,
   output logic             rdx
);

   localparam logic [2:0] OpClr = 3'd0;
   localparam logic [2:0] OpLdp = 3'd1;
   localparam logic [2:0] OpShr = 3'd2;
   localparam logic [2:0] OpLdd = 3'd3;
   localparam logic [2:0] OpRd  = 3'd4;

   typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StRead, StDone} state_e;

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       rdcnt_q, rdcnt_d;

   logic done_d, err_d, xiz_d, xip_d, xis_d, xid_d, wrx_d, rdx_d;
   logic sel_phase;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= StIdle;
         op_q    <= OpClr;
         cnt_q   <= '0;
         rdcnt_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         rdcnt_q <= rdcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      rdcnt_d = rdcnt_q;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               op_d  = cmd_op;
               cnt_d = cmd_cnt;
               case (cmd_op)
                  OpClr, OpLdp, OpLdd: state_d = StSetup;
                  OpShr:               state_d = (cmd_cnt != '0) ? StSetup : StDone;
                  OpRd: begin
                     state_d = StRead;
                     rdcnt_d = 4'(RD_CYCLES);
                  end
                  default:             state_d = StDone;
               endcase
            end
         end
         StSetup:  state_d = StStrobe;
         StStrobe: state_d = StHold;
         StHold: begin
            if (op_q == OpShr) cnt_d = cnt_q - CNT_W'(1);
            // Remaining shifts re-enter STROBE directly, keeping the select asserted.
            state_d = (op_q == OpShr && cnt_q > CNT_W'(1)) ? StStrobe : StDone;
         end
         StRead: begin
            rdcnt_d = rdcnt_q - 4'd1;
            if (rdcnt_q <= 4'd1) state_d = StDone;
         end
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so that every strobe is a flop output.
   always_comb begin
      sel_phase = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      wrx_d     = 1'b0;
      rdx_d     = 1'b0;
      unique case (state_d)
         StSetup, StHold: sel_phase = 1'b1;
         StStrobe: begin
            sel_phase = 1'b1;
            wrx_d     = 1'b1;
         end
         StRead:   rdx_d = 1'b1;
         StDone: begin
            done_d = 1'b1;
            err_d  = (op_d > OpRd);
         end
         default: ;
      endcase
      xiz_d = sel_phase && (op_d == OpClr);
      xip_d = sel_phase && (op_d == OpLdp);
      xis_d = sel_phase && (op_d == OpShr);
      xid_d = sel_phase && (op_d == OpLdd);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         done <= 1'b0;
         err  <= 1'b0;
         xiz  <= 1'b0;
         xip  <= 1'b0;
         xis  <= 1'b0;
         xid  <= 1'b0;
         wrx  <= 1'b0;
         rdx  <= 1'b0;
      end else begin
         done <= done_d;
         err  <= err_d;
         xiz  <= xiz_d;
         xip  <= xip_d;
         xis  <= xis_d;
         xid  <= xid_d;
         wrx  <= wrx_d;
         rdx  <= rdx_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_xreg_seq.sv
// Scoreboard bench for xreg_seq: a per-command model of select/wrx/rdx cycle masks
// and done latency is queued at issue and compared when done pulses.
module tb_xreg_seq;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned RD    = 2;

   logic             clk = 1'b0;
   logic             nrst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [CNT_W-1:0] cmd_cnt;
   logic             busy, done, err, xiz, xip, xis, xid, wrx, rdx;

   xreg_seq #(.CNT_W(CNT_W), .RD_CYCLES(RD)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_cnt   (cmd_cnt),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .xiz       (xiz),
      .xip       (xip),
      .xis       (xis),
      .xid       (xid),
      .wrx       (wrx),
      .rdx       (rdx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          lat;
      logic [63:0] wrx_m;
      logic [63:0] sel_m;
      logic [63:0] rdx_m;
      logic [3:0]  which;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_now = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [CNT_W-1:0] cnt);
      exp_t e;
      int   k;
      k       = int'(cnt);
      e.lat   = 1;
      e.wrx_m = '0;
      e.sel_m = '0;
      e.rdx_m = '0;
      e.which = '0;
      e.err   = 1'b0;
      case (op)
         3'd0, 3'd1, 3'd3: begin
            e.lat      = 4;
            e.wrx_m[2] = 1'b1;
            for (int i = 1; i <= 3; i++) e.sel_m[i] = 1'b1;
            e.which    = (op == 3'd0) ? 4'b0001 : (op == 3'd1) ? 4'b0010 : 4'b1000;
         end
         3'd2: begin
            if (k > 0) begin
               e.lat = 2 * k + 2;
               for (int i = 1; i <= k; i++) e.wrx_m[2*i] = 1'b1;
               for (int i = 1; i <= 2 * k + 1; i++) e.sel_m[i] = 1'b1;
               e.which = 4'b0100;
            end
         end
         3'd4: begin
            e.lat = RD + 1;
            for (int i = 1; i <= RD; i++) e.rdx_m[i] = 1'b1;
         end
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   always @(posedge clk) cyc_now++;

   // Monitor: tracks the active command cycle by cycle and scores it at done.
   bit          active = 1'b0;
   int          cyc;
   logic [63:0] m_wrx, m_sel, m_rdx;
   logic [3:0]  m_which;
   exp_t        e;

   always @(negedge clk) begin
      if (!nrst) begin
         active = 1'b0;
         sb.delete();
      end else begin
         check("onehot_sel", 64'($countones({xid, xis, xip, xiz}) <= 1), 64'd1);
         check("rdx_excl", 64'(rdx & (wrx | xiz | xip | xis | xid)), 64'd0);
         check("busy_vs_ready", 64'(busy), 64'(!cmd_ready));
         check("err_without_done", 64'(err & !done), 64'd0);
         if (active) begin
            cyc++;
            if (cyc < 64) begin
               m_wrx[cyc] = wrx;
               m_sel[cyc] = xiz | xip | xis | xid;
               m_rdx[cyc] = rdx;
            end
            m_which |= {xid, xis, xip, xiz};
            if (done) begin
               if (sb.size() == 0) check("scoreboard_empty", 64'd1, 64'd0);
               else begin
                  e = sb.pop_front();
                  check("done_latency", 64'(cyc), 64'(e.lat));
                  check("wrx_cycles", m_wrx, e.wrx_m);
                  check("sel_cycles", m_sel, e.sel_m);
                  check("rdx_cycles", m_rdx, e.rdx_m);
                  check("which_sel", 64'(m_which), 64'(e.which));
                  check("err_flag", 64'(err), 64'(e.err));
               end
               active = 1'b0;
            end
         end else if (done) begin
            check("spurious_done", 64'd1, 64'd0);
         end
         if (cmd_valid && cmd_ready) begin
            active  = 1'b1;
            cyc     = 0;
            m_wrx   = '0;
            m_sel   = '0;
            m_rdx   = '0;
            m_which = '0;
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [CNT_W-1:0] cnt, input bit keep,
                        output int acc);
      cmd_op    = op;
      cmd_cnt   = cnt;
      cmd_valid = 1'b1;
      sb.push_back(model(op, cnt));
      acc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk);
            #1;
            acc = cyc_now;
            break;
         end
      end
      if (acc < 0) check("accept_timeout", 64'd1, 64'd0);
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!active && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check(tag, 64'({busy, done, err, xiz, xip, xis, xid, wrx, rdx}), 64'd0);
      check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a1, a2;
      bit seen;
      nrst      = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_cnt   = '0;

      // 1. reset mid-clock, then CLR
      #13 nrst = 1'b0;
      #1 check_quiet("reset_outputs");
      repeat (2) @(posedge clk);
      #2 nrst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      issue(3'd0, '0, 1'b0, a1);
      wait_idle();

      // 2. LDD then LDP with valid held high
      issue(3'd3, '0, 1'b1, a1);
      issue(3'd1, '0, 1'b0, a2);
      check("b2b_accept_gap", 64'(a2 - a1), 64'd5);
      wait_idle();

      // 3-5. shifts, read, illegal ops
      issue(3'd2, 4'd3, 1'b0, a1);
      wait_idle();
      issue(3'd2, 4'd0, 1'b0, a1);
      wait_idle();
      issue(3'd2, 4'd15, 1'b0, a1);
      wait_idle();
      issue(3'd4, '0, 1'b0, a1);
      wait_idle();
      issue(3'd6, '0, 1'b0, a1);
      wait_idle();
      issue(3'd5, 4'd7, 1'b0, a1);
      issue(3'd7, '0, 1'b0, a1);
      issue(3'd2, 4'd1, 1'b0, a1);
      wait_idle();

      // 6. reset while wrx is high during SHR 5
      issue(3'd2, 4'd5, 1'b0, a1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wrx) begin
            seen = 1'b1;
            break;
         end
      end
      check("wrx_seen_before_abort", 64'(seen), 64'd1);
      #1 nrst = 1'b0;
      #1 check_quiet("abort_outputs");
      repeat (2) @(posedge clk);
      #2 nrst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      issue(3'd0, '0, 1'b0, a1);
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
